// File: rtl/spi_xfer_sequencer.sv
// Byte-stream front end for an SPI master: TX FIFO feeds one start/tx_data transaction per
// byte and each completed rx_data byte is captured into an RX FIFO for the host.
module spi_xfer_sequencer #(
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    tx_wr_en,
   input  logic [7:0]              tx_wr_data,
   output logic                    tx_full,
   output logic [$clog2(DEPTH):0]  tx_count,
   input  logic                    rx_rd_en,
   output logic [7:0]              rx_rd_data,
   output logic                    rx_empty,
   output logic [$clog2(DEPTH):0]  rx_count,
   output logic                    spi_start,
   output logic [7:0]              spi_tx_data,
   input  logic [7:0]              spi_rx_data,
   input  logic                    spi_busy,
   input  logic                    spi_done,
   output logic                    idle,
   output logic                    rx_overflow,
   output logic                    timeout_err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

   typedef enum logic [1:0] {StIdle, StIssue, StWaitDone} state_e;

   state_e         state_q, state_d;
   logic [TW-1:0]  tmo_cnt_q, tmo_cnt_d;
   logic           rx_overflow_q, rx_overflow_d;
   logic           timeout_err_q, timeout_err_d;
   logic [7:0]     spi_tx_data_q;

   logic [7:0]     tx_mem [DEPTH];
   logic [AW-1:0]  tx_wr_ptr_q, tx_rd_ptr_q;
   logic [CW-1:0]  tx_count_q;
   logic [7:0]     rx_mem [DEPTH];
   logic [AW-1:0]  rx_wr_ptr_q, rx_rd_ptr_q;
   logic [CW-1:0]  rx_count_q;

   logic tx_empty, rx_full;
   logic tx_push, tx_pop, rx_push, rx_pop, launch;

   assign tx_full  = (tx_count_q == CW'(DEPTH));
   assign tx_empty = (tx_count_q == '0);
   assign rx_full  = (rx_count_q == CW'(DEPTH));
   assign rx_empty = (rx_count_q == '0);

   // Holding off while RX is full guarantees every completed byte has a slot.
   assign launch  = (state_q == StIdle) && en && !tx_empty && !spi_busy && !rx_full;
   assign tx_push = tx_wr_en && !tx_full;
   assign tx_pop  = launch;
   assign rx_push = (state_q == StWaitDone) && spi_done && !rx_full;
   assign rx_pop  = rx_rd_en && !rx_empty;

   assign tx_count    = tx_count_q;
   assign rx_count    = rx_count_q;
   assign rx_rd_data  = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr_q];
   assign spi_start   = (state_q == StIssue);
   assign spi_tx_data = spi_tx_data_q;
   assign idle        = (state_q == StIdle) && tx_empty;
   assign rx_overflow = rx_overflow_q;
   assign timeout_err = timeout_err_q;

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr_ptr_q] <= tx_wr_data;
      if (rx_push) rx_mem[rx_wr_ptr_q] <= spi_rx_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tx_wr_ptr_q <= '0;
         tx_rd_ptr_q <= '0;
         tx_count_q  <= '0;
         rx_wr_ptr_q <= '0;
         rx_rd_ptr_q <= '0;
         rx_count_q  <= '0;
      end else begin
         if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + AW'(1);
         if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + AW'(1);
         if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + AW'(1);
         if (rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + AW'(1);
         tx_count_q <= tx_count_q + CW'(tx_push) - CW'(tx_pop);
         rx_count_q <= rx_count_q + CW'(rx_push) - CW'(rx_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         tmo_cnt_q     <= '0;
         rx_overflow_q <= 1'b0;
         timeout_err_q <= 1'b0;
         spi_tx_data_q <= 8'h00;
      end else begin
         state_q       <= state_d;
         tmo_cnt_q     <= tmo_cnt_d;
         rx_overflow_q <= rx_overflow_d;
         timeout_err_q <= timeout_err_d;
         if (launch) spi_tx_data_q <= tx_mem[tx_rd_ptr_q];
      end
   end

   // tmo_cnt counts cycles since the ISSUE cycle, so the abort lands TIMEOUT_CYC edges later.
   always_comb begin
      state_d       = state_q;
      tmo_cnt_d     = tmo_cnt_q;
      rx_overflow_d = rx_overflow_q;
      timeout_err_d = timeout_err_q;
      unique case (state_q)
         StIdle: begin
            if (launch) state_d = StIssue;
         end
         StIssue: begin
            state_d   = StWaitDone;
            tmo_cnt_d = TW'(1);
         end
         StWaitDone: begin
            if (spi_done) begin
               state_d = StIdle;
               if (rx_full) rx_overflow_d = 1'b1;
            end else if ((TIMEOUT_CYC != 0) && (32'(tmo_cnt_q) >= TIMEOUT_CYC - 1)) begin
               state_d       = StIdle;
               timeout_err_d = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

endmodule
